// File: rtl/audio_pkg.sv
// Shared types for the audio sample FIFO.
// Assembler states, mode encoding and frame size.
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    WAIT,
    DONE
  } state_e;

  // {mode_16bit, mode_stereo}
  typedef logic [1:0] mode_t;

  localparam mode_t M_MONO8    = 2'b00;
  localparam mode_t M_STEREO8  = 2'b01;
  localparam mode_t M_MONO16   = 2'b10;
  localparam mode_t M_STEREO16 = 2'b11;

  function automatic logic [2:0] bytes_per_frame(input mode_t m);
    logic [2:0] n;
    unique case (m)
      M_MONO8:   n = 3'd1;
      M_STEREO8: n = 3'd2;
      M_MONO16:  n = 3'd2;
      default:   n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/audio_fifo_ram.sv
// Simple dual-port byte RAM for the audio FIFO.
// Synchronous write, registered synchronous read.
module audio_fifo_ram #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem_q [2**ADDR_W];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/audio_sample_fifo.sv
// Byte FIFO with level/flags and a read-side
// sample assembler for the PCM playback engine.
module audio_sample_fifo
  import audio_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      wr_data,
  input  logic            wr_en,
  input  logic            flush,
  input  logic            clear_flags,
  input  logic [ADDR_W:0] ae_thresh,
  input  logic            mode_16bit,
  input  logic            mode_stereo,
  input  logic            sample_req,
  output logic            sample_valid,
  output logic [15:0]     left,
  output logic [15:0]     right,
  output logic            busy,
  output logic [ADDR_W:0] level,
  output logic            empty,
  output logic            full,
  output logic            almost_empty,
  output logic            overflow,
  output logic            underrun
);

  typedef logic [ADDR_W:0] ptr_t;

  localparam ptr_t DEPTH_L = ptr_t'(2**ADDR_W);
  localparam ptr_t ONE     = ptr_t'(1);

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  ptr_t lvl;

  state_e state_q, state_d;
  mode_t  mode_q, mode_d, mode_in;

  logic [1:0]      pop_cnt_q, pop_cnt_d;
  logic [1:0]      cap_cnt_q, cap_cnt_d;
  logic [1:0]      last_idx;
  logic            rd_vld_q, rd_vld_d;
  logic [3:0][7:0] byte_q, byte_d;
  logic            und_q, und_d;
  logic            sv_q, sv_d;
  logic [15:0]     left_q, left_d;
  logic [15:0]     right_q, right_d;
  logic            ovf_q, ovf_d;
  logic            urn_q, urn_d;
  logic            urn_set;

  logic       push, pop;
  logic [2:0] need;
  logic [7:0] rdata;

  assign lvl      = wr_ptr_q - rd_ptr_q;
  assign full     = (lvl == DEPTH_L);
  assign empty    = (lvl == '0);
  assign mode_in  = {mode_16bit, mode_stereo};
  assign need     = bytes_per_frame(mode_in);
  assign last_idx = 2'(bytes_per_frame(mode_q) - 3'd1);
  assign push     = wr_en && !full && !flush;
  assign pop      = (state_q == POP) && !flush;

  audio_fifo_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .wdata (wr_data),
    .re    (pop),
    .raddr (rd_ptr_q[ADDR_W-1:0]),
    .rdata (rdata)
  );

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    state_d   = state_q;
    mode_d    = mode_q;
    pop_cnt_d = pop_cnt_q;
    cap_cnt_d = cap_cnt_q;
    rd_vld_d  = pop;
    byte_d    = byte_q;
    und_d     = und_q;
    sv_d      = 1'b0;
    left_d    = left_q;
    right_d   = right_q;
    urn_set   = 1'b0;

    if (push) wr_ptr_d = wr_ptr_q + ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + ONE;

    // RAM data lands one cycle after its pop
    if (rd_vld_q) begin
      byte_d[cap_cnt_q] = rdata;
      cap_cnt_d = cap_cnt_q + 2'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (sample_req && !flush) begin
          pop_cnt_d = '0;
          cap_cnt_d = '0;
          if (lvl >= ptr_t'(need)) begin
            mode_d  = mode_in;
            und_d   = 1'b0;
            state_d = POP;
          end else begin
            und_d   = 1'b1;
            urn_set = 1'b1;
            state_d = DONE;
          end
        end
      end
      POP: begin
        pop_cnt_d = pop_cnt_q + 2'd1;
        if (pop_cnt_q == last_idx) state_d = WAIT;
      end
      WAIT: state_d = DONE;
      DONE: begin
        sv_d    = 1'b1;
        state_d = IDLE;
        if (und_q) begin
          left_d  = '0;
          right_d = '0;
        end else begin
          unique case (mode_q)
            M_MONO8: begin
              left_d  = {byte_q[0], 8'h00};
              right_d = {byte_q[0], 8'h00};
            end
            M_STEREO8: begin
              left_d  = {byte_q[0], 8'h00};
              right_d = {byte_q[1], 8'h00};
            end
            M_MONO16: begin
              left_d  = {byte_q[1], byte_q[0]};
              right_d = {byte_q[1], byte_q[0]};
            end
            default: begin
              left_d  = {byte_q[1], byte_q[0]};
              right_d = {byte_q[3], byte_q[2]};
            end
          endcase
        end
      end
      default: state_d = IDLE;
    endcase

    ovf_d = (ovf_q && !clear_flags) || (wr_en && full);
    urn_d = (urn_q && !clear_flags) || urn_set;

    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      state_d  = IDLE;
      sv_d     = 1'b0;
      left_d   = left_q;
      right_d  = right_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      state_q   <= IDLE;
      mode_q    <= M_MONO8;
      pop_cnt_q <= '0;
      cap_cnt_q <= '0;
      rd_vld_q  <= 1'b0;
      byte_q    <= '0;
      und_q     <= 1'b0;
      sv_q      <= 1'b0;
      left_q    <= '0;
      right_q   <= '0;
      ovf_q     <= 1'b0;
      urn_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      state_q   <= state_d;
      mode_q    <= mode_d;
      pop_cnt_q <= pop_cnt_d;
      cap_cnt_q <= cap_cnt_d;
      rd_vld_q  <= rd_vld_d;
      byte_q    <= byte_d;
      und_q     <= und_d;
      sv_q      <= sv_d;
      left_q    <= left_d;
      right_q   <= right_d;
      ovf_q     <= ovf_d;
      urn_q     <= urn_d;
    end
  end

  assign sample_valid = sv_q;
  assign left         = left_q;
  assign right        = right_q;
  assign busy         = (state_q != IDLE);
  assign level        = lvl;
  assign almost_empty = (lvl < ae_thresh);
  assign overflow     = ovf_q;
  assign underrun     = urn_q;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Testbench for audio_sample_fifo (16-byte depth).
// Queue-based reference model with directed and random steps.
module tb_audio_sample_fifo;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    wr_data = '0;
  logic          wr_en = 1'b0;
  logic          flush = 1'b0;
  logic          clear_flags = 1'b0;
  logic [AW:0]   ae_thresh = 5'd8;
  logic          mode_16bit = 1'b0;
  logic          mode_stereo = 1'b0;
  logic          sample_req = 1'b0;
  logic          sample_valid;
  logic [15:0]   left, right;
  logic          busy;
  logic [AW:0]   level;
  logic          empty, full, almost_empty, overflow, underrun;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  audio_sample_fifo #(.ADDR_W(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .flush        (flush),
    .clear_flags  (clear_flags),
    .ae_thresh    (ae_thresh),
    .mode_16bit   (mode_16bit),
    .mode_stereo  (mode_stereo),
    .sample_req   (sample_req),
    .sample_valid (sample_valid),
    .left         (left),
    .right        (right),
    .busy         (busy),
    .level        (level),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underrun     (underrun)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    wr_data = b;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    if (q.size() < DEPTH) q.push_back(b);
  endtask

  task automatic frame(input bit m16, input bit st, input string tag);
    int n, lat, exp_lat;
    logic [15:0] el, er;
    logic [7:0] b[4];
    n = (m16 ? 2 : 1) * (st ? 2 : 1);
    el = '0;
    er = '0;
    if (q.size() < n) begin
      exp_lat = 1;
    end else begin
      exp_lat = n + 2;
      for (int i = 0; i < n; i++) b[i] = q.pop_front();
      if (m16) begin
        el = {b[1], b[0]};
        er = st ? {b[3], b[2]} : el;
      end else begin
        el = {b[0], 8'h00};
        er = st ? {b[1], 8'h00} : el;
      end
    end
    mode_16bit = m16;
    mode_stereo = st;
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!sample_valid && lat < 20);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_left"}, left, el);
    chk({tag, "_right"}, right, er);
    tick();
    chk({tag, "_pulse"}, sample_valid, 1'b0);
  endtask

  initial begin
    int nb, ph, mlvl, cyc, seen;
    bit do_wr, do_req, ev, pop_now, wr_ok;
    logic [15:0] pend;

    // reset values
    tick();
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_valid", sample_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_urn", underrun, 0);
    chk("rst_left", left, 0);
    rst_n = 1'b1;
    tick();

    // fill, almost-empty edge, overflow
    for (int i = 0; i < 7; i++) push_byte(8'($urandom));
    chk("ae_lvl7", almost_empty, 1);
    chk("lvl7", level, 7);
    push_byte(8'($urandom));
    chk("ae_lvl8", almost_empty, 0);
    for (int i = 0; i < 8; i++) push_byte(8'($urandom));
    chk("full_lvl", level, 16);
    chk("full_flag", full, 1);
    chk("no_ovf", overflow, 0);
    push_byte(8'hEE);
    chk("ovf_lvl", level, 16);
    chk("ovf_flag", overflow, 1);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    chk("ovf_clr", overflow, 0);
    for (int i = 0; i < 4; i++) frame(1, 1, "readback");
    chk("rb_empty", empty, 1);
    ae_thresh = '0;

    // stereo16 directed
    push_byte(8'h34);
    push_byte(8'h12);
    push_byte(8'hCD);
    push_byte(8'hAB);
    chk("s16_lvl", level, 4);
    frame(1, 1, "s16");
    chk("s16_l", left, 16'h1234);
    chk("s16_r", right, 16'hABCD);
    chk("s16_lvl0", level, 0);
    chk("s16_empty", empty, 1);

    // 8-bit modes
    push_byte(8'h80);
    frame(0, 0, "m8");
    chk("m8_l", left, 16'h8000);
    chk("m8_lvl", level, 0);
    push_byte(8'h01);
    push_byte(8'hFF);
    frame(0, 1, "st8");
    chk("st8_r", right, 16'hFF00);

    // underrun
    push_byte(8'h5A);
    frame(1, 1, "urn");
    chk("urn_flag", underrun, 1);
    chk("urn_lvl", level, 1);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    chk("urn_clr", underrun, 0);
    frame(0, 0, "urn_drain");

    // random concurrent push / mono16 request stream
    nb = 0;
    ph = 0;
    mlvl = 0;
    cyc = 0;
    pend = '0;
    mode_16bit = 1'b1;
    mode_stereo = 1'b0;
    while (!(nb >= 200 && ph == 0 && mlvl < 2) && cyc < 3000) begin
      do_wr = (nb < 200) && ($urandom % 4 != 0);
      do_req = ($urandom % 3 == 0);
      wr_en = do_wr;
      wr_data = nb[7:0];
      sample_req = do_req;
      ev = (ph == 4);
      pop_now = (ph == 1 || ph == 2);
      wr_ok = do_wr && (mlvl < DEPTH);
      if (wr_ok) q.push_back(wr_data);
      if (do_wr) nb++;
      if (do_req && ph == 0) begin
        if (mlvl >= 2) begin
          pend[7:0] = q.pop_front();
          pend[15:8] = q.pop_front();
          ph = 1;
        end else begin
          pend = '0;
          ph = 4;
        end
      end else if (ev) begin
        ph = 0;
      end else if (ph != 0) begin
        ph++;
      end
      mlvl = mlvl + int'(wr_ok) - int'(pop_now);
      tick();
      chk("wrap_valid", sample_valid, ev);
      chk("wrap_level", level, mlvl);
      if (ev) begin
        chk("wrap_left", left, ev ? pend : 16'h0);
        chk("wrap_right", right, pend);
      end
      if (ev && ph == 0) pend = pend;
      cyc++;
    end
    wr_en = 1'b0;
    sample_req = 1'b0;
    chk("wrap_bound", cyc < 3000, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    q.delete();
    chk("wrap_flush", level, 0);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;

    // flush during POP
    for (int i = 0; i < 4; i++) push_byte(8'(i + 8'h40));
    mode_16bit = 1'b1;
    mode_stereo = 1'b1;
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    tick();
    chk("fl_busy1", busy, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    q.delete();
    chk("fl_level", level, 0);
    chk("fl_busy0", busy, 0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (sample_valid) seen++;
      tick();
    end
    chk("fl_novalid", seen, 0);
    chk("fl_ovf", overflow, 0);

    // async reset mid-frame
    push_byte(8'h11);
    push_byte(8'h22);
    frame(1, 0, "pre_rst");
    for (int i = 0; i < 4; i++) push_byte(8'(i + 8'h70));
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    tick();
    chk("ar_busy1", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_level", level, 0);
    chk("ar_busy", busy, 0);
    chk("ar_empty", empty, 1);
    chk("ar_valid", sample_valid, 0);
    chk("ar_left", left, 0);
    chk("ar_right", right, 0);
    tick();
    rst_n = 1'b1;
    q.delete();
    tick();
    chk("ar_after", sample_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
